// File: rtl/cpu_ifetch.sv
// Instruction-fetch bus master: latches the PC, runs one Avalon-MM read and captures the word.
// Latency: fetch_req -> avm_read 1 cycle; zero-wait slave -> instr_valid 2 cycles (+1 per wait cycle).
// Backpressure: holds the read while avm_waitrequest=1; aborts to a sticky ERR state on timeout.
//
// Ports:
//   clk, reset (async active-low)
//   fetch_req / pc_i                      - fetch request from control, PC from cpu_pc
//   avm_address/read/byteenable           - Avalon-MM read master outputs
//   avm_waitrequest/readdata              - Avalon-MM slave responses
//   instr_o / instr_valid / pc_wen_o      - instruction register, update pulse, PC advance pulse
//   busy / bus_err                        - not idle / sticky timeout or misalignment error
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   When defined, a request with pc_i[1:0]!=0 goes straight to ERR without a bus read.
//   When undefined, the low two address bits are forced to zero and the fetch proceeds.
module cpu_ifetch #(
   parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] pc_i,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [31:0] instr_o,
   output logic        instr_valid,
   output logic        pc_wen_o,
   output logic        busy,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);
   localparam bit               TO_EN  = (TIMEOUT_CYC != 0);

   state_t             state_q, state_d;
   logic [31:0]        addr_q;
   logic [31:0]        instr_q;
   logic [CNT_W-1:0]   cnt_q;

   wire accept = (state_q == S_IDLE) && fetch_req;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (fetch_req) begin
`ifdef IFETCH_ALIGN_CHECK_EN
               if (pc_i[1:0] != 2'b00) state_d = S_ERR;
               else                    state_d = S_REQ;
`else
               state_d = S_REQ;
`endif
            end
         end
         S_REQ: begin
            if (!avm_waitrequest)                  state_d = S_DONE;
            else if (TO_EN && (cnt_q == TO_LIM))   state_d = S_ERR;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_ERR;   // only reset leaves ERR
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: everything decodes from registered state, so bus outputs only move on posedge.
   always_comb begin
      avm_read       = 1'b0;
      avm_byteenable = 4'b0000;
      instr_valid    = 1'b0;
      pc_wen_o       = 1'b0;
      busy           = 1'b1;
      bus_err        = 1'b0;
      case (state_q)
         S_IDLE: busy = 1'b0;
         S_REQ: begin
            avm_read       = 1'b1;
            avm_byteenable = 4'b1111;
         end
         S_DONE: begin
            instr_valid = 1'b1;
            pc_wen_o    = 1'b1;
         end
         S_ERR:   bus_err = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Datapath: address latch, instruction register, saturating wait counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= 32'h0;
         instr_q <= RESET_INSTR;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            // Word-aligned address; pc_i is not looked at again until the next request.
            addr_q <= pc_i & 32'hFFFF_FFFC;
            cnt_q  <= '0;
         end
         if (state_q == S_REQ) begin
            if (!avm_waitrequest) begin
               instr_q <= avm_readdata;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (state_q == S_DONE) begin
            cnt_q <= '0;
         end
      end
   end

   assign avm_address = addr_q;
   assign instr_o     = instr_q;

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch: reset, zero-wait fetch, wait-state fetch, async reset mid-read,
// timeout to ERR, back-to-back fetches and the misaligned-PC case.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cpu_ifetch;

   logic        clk;
   logic        reset;
   logic        fetch_req;
   logic [31:0] pc_i;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [31:0] instr_o;
   logic        instr_valid;
   logic        pc_wen_o;
   logic        busy;
   logic        bus_err;

   int n_vec = 0;
   int n_err = 0;

   cpu_ifetch #(
      .RESET_INSTR (32'h0000_0000),
      .TIMEOUT_CYC (4),
      .CNT_W       (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_req       (fetch_req),
      .pc_i            (pc_i),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .instr_o         (instr_o),
      .instr_valid     (instr_valid),
      .pc_wen_o        (pc_wen_o),
      .busy            (busy),
      .bus_err         (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [11:0] wen_mask;
      int          wen_seen;

      reset           = 1'b0;
      fetch_req       = 1'b0;
      pc_i            = 32'h0;
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'h0;
      #12;

      // ---- reset state ----
      chk("rst_read",   {31'h0, avm_read},       32'h0);
      chk("rst_addr",   avm_address,             32'h0);
      chk("rst_be",     {28'h0, avm_byteenable}, 32'h0);
      chk("rst_instr",  instr_o,                 32'h0);
      chk("rst_valid",  {31'h0, instr_valid},    32'h0);
      chk("rst_wen",    {31'h0, pc_wen_o},       32'h0);
      chk("rst_busy",   {31'h0, busy},           32'h0);
      chk("rst_err",    {31'h0, bus_err},        32'h0);
      reset = 1'b1;
      tick();

      // ---- zero-wait fetch (cycle 0 = request) ----
      fetch_req = 1'b1; pc_i = 32'hBFC0_0000;
      avm_waitrequest = 1'b0; avm_readdata = 32'h2402_000A;
      tick();   // cycle 1
      fetch_req = 1'b0;
      chk("zw_c1_read",  {31'h0, avm_read},       32'h1);
      chk("zw_c1_addr",  avm_address,             32'hBFC0_0000);
      chk("zw_c1_be",    {28'h0, avm_byteenable}, 32'hF);
      chk("zw_c1_valid", {31'h0, instr_valid},    32'h0);
      tick();   // cycle 2
      chk("zw_c2_instr", instr_o,                 32'h2402_000A);
      chk("zw_c2_valid", {31'h0, instr_valid},    32'h1);
      chk("zw_c2_wen",   {31'h0, pc_wen_o},       32'h1);
      chk("zw_c2_read",  {31'h0, avm_read},       32'h0);
      tick();   // cycle 3
      chk("zw_c3_busy",  {31'h0, busy},           32'h0);
      chk("zw_c3_valid", {31'h0, instr_valid},    32'h0);

      // ---- three wait cycles, pc_i changed during the wait ----
      fetch_req = 1'b1; pc_i = 32'hBFC0_0000; avm_readdata = 32'h8C08_0004;
      tick();   // cycle 1
      fetch_req = 1'b0; pc_i = 32'h0; avm_waitrequest = 1'b1;
      chk("ws_c1_addr",  avm_address,          32'hBFC0_0000);
      chk("ws_c1_read",  {31'h0, avm_read},    32'h1);
      tick();   // cycle 2
      chk("ws_c2_addr",  avm_address,          32'hBFC0_0000);
      chk("ws_c2_valid", {31'h0, instr_valid}, 32'h0);
      tick();   // cycle 3
      chk("ws_c3_addr",  avm_address,          32'hBFC0_0000);
      tick();   // cycle 4
      avm_waitrequest = 1'b0;
      chk("ws_c4_addr",  avm_address,          32'hBFC0_0000);
      chk("ws_c4_read",  {31'h0, avm_read},    32'h1);
      chk("ws_c4_valid", {31'h0, instr_valid}, 32'h0);
      tick();   // cycle 5
      chk("ws_c5_valid", {31'h0, instr_valid}, 32'h1);
      chk("ws_c5_instr", instr_o,              32'h8C08_0004);
      tick();   // cycle 6
      chk("ws_c6_busy",  {31'h0, busy},        32'h0);

      // ---- async reset while a stalled read is in flight ----
      fetch_req = 1'b1; pc_i = 32'h0000_0100; avm_waitrequest = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("ar_pre_read", {31'h0, avm_read},    32'h1);
      #3;
      reset = 1'b0;
      #1;
      chk("ar_read",  {31'h0, avm_read},  32'h0);
      chk("ar_instr", instr_o,            32'h0);
      chk("ar_busy",  {31'h0, busy},      32'h0);
      chk("ar_err",   {31'h0, bus_err},   32'h0);
      chk("ar_addr",  avm_address,        32'h0);
      #2;
      reset = 1'b1;
      tick();

      // ---- timeout: waitrequest stuck high, limit 4 ----
      avm_waitrequest = 1'b1; avm_readdata = 32'hDEAD_BEEF;
      fetch_req = 1'b1; pc_i = 32'h0000_0200;
      wen_seen = 0;
      tick();   // cycle 1
      fetch_req = 1'b0;
      chk("to_c1_read", {31'h0, avm_read}, 32'h1);
      for (int i = 2; i <= 4; i++) begin
         tick();
         if (pc_wen_o) wen_seen++;
      end
      chk("to_c4_err",  {31'h0, bus_err},  32'h0);
      chk("to_c4_read", {31'h0, avm_read}, 32'h1);
      tick();   // cycle 5
      if (pc_wen_o) wen_seen++;
      tick();   // cycle 6
      if (pc_wen_o) wen_seen++;
      chk("to_c6_err",   {31'h0, bus_err},        32'h1);
      chk("to_c6_read",  {31'h0, avm_read},       32'h0);
      chk("to_c6_be",    {28'h0, avm_byteenable}, 32'h0);
      chk("to_c6_busy",  {31'h0, busy},           32'h1);
      chk("to_c6_instr", instr_o,                 32'h0);
      // Requests in ERR must be ignored
      fetch_req = 1'b1; avm_waitrequest = 1'b0; pc_i = 32'h0000_0300;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (pc_wen_o || avm_read) wen_seen++;
      end
      chk("to_sticky_err", {31'h0, bus_err}, 32'h1);
      chk("to_no_activity", wen_seen,        32'h0);
      fetch_req = 1'b0;
      reset = 1'b0;
      #2;
      chk("to_rst_err", {31'h0, bus_err}, 32'h0);
      reset = 1'b1;
      tick();

      // ---- back-to-back: fetch_req held for 9 cycles ----
      avm_waitrequest = 1'b0; avm_readdata = 32'h0000_0000;
      pc_i = 32'h0000_0400;
      fetch_req = 1'b1;
      wen_mask = '0;
      wen_seen = 0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c == 9) fetch_req = 1'b0;
         if (pc_wen_o) begin
            wen_mask[c] = 1'b1;
            wen_seen++;
         end
      end
      chk("b2b_count", wen_seen,                32'd3);
      chk("b2b_mask",  {20'h0, wen_mask},       32'h0000_0124);

      // ---- misaligned PC ----
      fetch_req = 1'b1; pc_i = 32'hBFC0_0002;
      tick();   // cycle 1
      fetch_req = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      chk("mis_err",  {31'h0, bus_err},  32'h1);
      chk("mis_read", {31'h0, avm_read}, 32'h0);
      wen_seen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (avm_read || pc_wen_o) wen_seen++;
      end
      chk("mis_no_read", wen_seen, 32'h0);
`else
      chk("mis_addr", avm_address,        32'hBFC0_0000);
      chk("mis_read", {31'h0, avm_read},  32'h1);
      tick();
      chk("mis_wen",  {31'h0, pc_wen_o},  32'h1);
      chk("mis_err",  {31'h0, bus_err},   32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
